// File: rtl/rs.sv
// Five-entry reservation station: one slot per functional unit (ALU, LOAD, STORE, MULT0, MULT1).
// Accepts one decoded instruction per cycle and issues at most one held entry per cycle.

package rs_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLT    = 4'd2,
        ALU_SLTU   = 4'd3,
        ALU_AND    = 4'd4,
        ALU_OR     = 4'd5,
        ALU_XOR    = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_MUL    = 4'd10,
        ALU_MULH   = 4'd11,
        ALU_MULHSU = 4'd12,
        ALU_MULHU  = 4'd13,
        ALU_DIV    = 4'd14,
        ALU_REM    = 4'd15
    } ALU_FUNC;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  dest_reg;
        ALU_FUNC     alu_func;
        logic        rd_mem;
        logic        wr_mem;
        logic        valid;
    } DECODER_PACKET;

    typedef struct packed {
        DECODER_PACKET decoder_packet;
        logic          write_en;
    } ID_RS_PACKET;

    typedef struct packed {
        logic [2:0] remove_idx;
        logic       remove_en;
    } EX_RS_PACKET;

    typedef struct packed {
        logic [2:0] free_idx;
        logic       free;
    } RS_ID_PACKET;

    typedef struct packed {
        DECODER_PACKET decoder_packet;
        logic          issue_en;
    } RS_IS_PACKET;

endpackage

module rs
    import rs_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        cdb_en,
    input  ID_RS_PACKET id_rs_packet,
    input  EX_RS_PACKET ex_rs_packet,
    output RS_ID_PACKET rs_id_packet,
    output RS_IS_PACKET rs_is_packet,
    output logic [4:0]  rs_busy_status,
    output logic        is_mult
);

    localparam int         NUM_ENTRIES = 5;
    localparam logic [2:0] SLOT_ALU    = 3'd0;
    localparam logic [2:0] SLOT_LOAD   = 3'd1;
    localparam logic [2:0] SLOT_STORE  = 3'd2;
    localparam logic [2:0] SLOT_MULT0  = 3'd3;
    localparam logic [2:0] SLOT_MULT1  = 3'd4;

    // Single-cycle units share the CDB; only the multiplier slots may issue while it is reserved.
    localparam logic [4:0] CDB_BLOCKED_MASK = 5'b11000;

    logic [4:0]    busy_q, busy_d;
    logic [4:0]    issued_q, issued_d;
    DECODER_PACKET entry_q [NUM_ENTRIES];
    DECODER_PACKET entry_d [NUM_ENTRIES];

    DECODER_PACKET id_pkt;
    logic          id_is_mult;
    logic [2:0]    free_idx;
    logic          free;
    logic [7:0]    busy_ext;

    logic [4:0]    dispatch_mask;
    logic [4:0]    remove_mask;
    logic [4:0]    candidates;
    logic [4:0]    win_mask;
    logic          win_found;
    DECODER_PACKET issue_pkt;
    logic          issue_is_mult;

    assign id_pkt   = id_rs_packet.decoder_packet;
    assign busy_ext = {3'b000, busy_q};

    always_comb begin
        id_is_mult = 1'b0;
        case (id_pkt.alu_func)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: id_is_mult = 1'b1;
            default:                                 id_is_mult = 1'b0;
        endcase
    end

    // Store takes priority over load, and both over the ALU function field.
    always_comb begin
        free_idx = SLOT_ALU;
        if (id_pkt.wr_mem) begin
            free_idx = SLOT_STORE;
        end else if (id_pkt.rd_mem) begin
            free_idx = SLOT_LOAD;
        end else if (id_is_mult) begin
            free_idx = busy_q[3] ? SLOT_MULT1 : SLOT_MULT0;
        end else begin
            free_idx = SLOT_ALU;
        end
    end

    assign free = ~busy_ext[free_idx];

    always_comb begin
        dispatch_mask = 5'b00000;
        if (id_rs_packet.write_en && free) begin
            dispatch_mask = 5'(8'd1 << free_idx);
        end
    end

    // Out-of-range indices shift past bit 4 and leave an empty mask.
    always_comb begin
        remove_mask = 5'b00000;
        if (ex_rs_packet.remove_en) begin
            remove_mask = 5'(8'd1 << ex_rs_packet.remove_idx);
        end
    end

    assign candidates = busy_q & ~issued_q & (cdb_en ? CDB_BLOCKED_MASK : 5'b11111);

    always_comb begin
        win_mask      = 5'b00000;
        win_found     = 1'b0;
        issue_pkt     = '0;
        issue_is_mult = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!win_found && candidates[i]) begin
                win_found     = 1'b1;
                win_mask[i]   = 1'b1;
                issue_pkt     = entry_q[i];
                issue_is_mult = (i >= 3);
            end
        end
    end

    // Removal is applied last so it wins over issue marking of the same slot.
    always_comb begin
        busy_d   = busy_q;
        issued_d = issued_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (interrupt) begin
            busy_d   = 5'b00000;
            issued_d = 5'b00000;
        end else begin
            issued_d = issued_q | win_mask;
            busy_d   = busy_q | dispatch_mask;
            issued_d = issued_d & ~dispatch_mask;
            busy_d   = busy_d & ~remove_mask;
            issued_d = issued_d & ~remove_mask;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (dispatch_mask[i]) begin
                    entry_d[i] = id_pkt;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q   <= 5'b00000;
            issued_q <= 5'b00000;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            busy_q   <= busy_d;
            issued_q <= issued_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign rs_id_packet.free_idx       = free_idx;
    assign rs_id_packet.free           = free;
    assign rs_is_packet.decoder_packet = issue_pkt;
    assign rs_is_packet.issue_en       = win_found;
    assign rs_busy_status              = busy_q;
    assign is_mult                     = issue_is_mult;

endmodule

// File: tb/tb_rs.sv
// Directed bench for the reservation station: dispatch classification, issue priority,
// removal, CDB blocking, interrupt flush and asynchronous reset.

module tb_rs;
    import rs_pkg::*;

    logic        clock;
    logic        reset;
    logic        interrupt;
    logic        cdb_en;
    ID_RS_PACKET id_rs_packet;
    EX_RS_PACKET ex_rs_packet;
    RS_ID_PACKET rs_id_packet;
    RS_IS_PACKET rs_is_packet;
    logic [4:0]  rs_busy_status;
    logic        is_mult;

    int tests;
    int fails;

    rs dut (
        .clock          (clock),
        .reset          (reset),
        .interrupt      (interrupt),
        .cdb_en         (cdb_en),
        .id_rs_packet   (id_rs_packet),
        .ex_rs_packet   (ex_rs_packet),
        .rs_id_packet   (rs_id_packet),
        .rs_is_packet   (rs_is_packet),
        .rs_busy_status (rs_busy_status),
        .is_mult        (is_mult)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic DECODER_PACKET mk(input logic rd, input logic wr, input ALU_FUNC f,
                                         input logic [31:0] inst);
        DECODER_PACKET p;
        p          = '0;
        p.inst     = inst;
        p.pc       = inst + 32'h100;
        p.alu_func = f;
        p.rd_mem   = rd;
        p.wr_mem   = wr;
        p.valid    = 1'b1;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input DECODER_PACKET p, input logic we);
        id_rs_packet.decoder_packet = p;
        id_rs_packet.write_en       = we;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_issue(input string tag, input logic en, input logic m, input logic [31:0] inst);
        chk({tag, "_issue_en"}, 32'(rs_is_packet.issue_en), 32'(en));
        chk({tag, "_is_mult"}, 32'(is_mult), 32'(m));
        chk({tag, "_inst"}, rs_is_packet.decoder_packet.inst, inst);
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        interrupt    = 1'b0;
        cdb_en       = 1'b0;
        id_rs_packet = '0;
        ex_rs_packet = '0;

        #2;
        chk("rst_busy", 32'(rs_busy_status), 32'h0);
        chk("rst_free", 32'(rs_id_packet.free), 32'h1);
        chk("rst_free_idx", 32'(rs_id_packet.free_idx), 32'h0);
        chk_issue("rst", 1'b0, 1'b0, 32'h0);
        reset = 1'b0;

        // Load into slot 1
        drive(mk(1'b1, 1'b0, ALU_ADD, 32'hA1), 1'b1);
        #1;
        chk("ld_free_idx", 32'(rs_id_packet.free_idx), 32'd1);
        chk("ld_free", 32'(rs_id_packet.free), 32'd1);
        tick();
        drive('0, 1'b0);
        #1;
        chk("ld_busy", 32'(rs_busy_status), 32'b00010);
        chk_issue("ld", 1'b1, 1'b0, 32'hA1);
        tick();
        chk_issue("ld_done", 1'b0, 1'b0, 32'h0);

        // Store into slot 2, then a load is refused
        drive(mk(1'b0, 1'b1, ALU_ADD, 32'hA2), 1'b1);
        #1;
        chk("st_free_idx", 32'(rs_id_packet.free_idx), 32'd2);
        chk("st_free", 32'(rs_id_packet.free), 32'd1);
        tick();
        drive(mk(1'b1, 1'b0, ALU_ADD, 32'hBAD), 1'b1);
        #1;
        chk("st_busy", 32'(rs_busy_status), 32'b00110);
        chk_issue("st", 1'b1, 1'b0, 32'hA2);
        chk("ld2_free_idx", 32'(rs_id_packet.free_idx), 32'd1);
        chk("ld2_free", 32'(rs_id_packet.free), 32'd0);
        tick();
        drive('0, 1'b0);
        #1;
        chk("ld2_busy", 32'(rs_busy_status), 32'b00110);
        chk_issue("ld2", 1'b0, 1'b0, 32'h0);

        // Multiplies fill slot 3, then slot 4, then are refused
        drive(mk(1'b0, 1'b0, ALU_MUL, 32'hA3), 1'b1);
        #1;
        chk("mul1_free_idx", 32'(rs_id_packet.free_idx), 32'd3);
        chk("mul1_free", 32'(rs_id_packet.free), 32'd1);
        tick();
        drive(mk(1'b0, 1'b0, ALU_MULHU, 32'hA4), 1'b1);
        #1;
        chk("mul1_busy", 32'(rs_busy_status), 32'b01110);
        chk_issue("mul1", 1'b1, 1'b1, 32'hA3);
        chk("mul2_free_idx", 32'(rs_id_packet.free_idx), 32'd4);
        chk("mul2_free", 32'(rs_id_packet.free), 32'd1);
        tick();
        drive(mk(1'b0, 1'b0, ALU_MULH, 32'hBAD), 1'b1);
        #1;
        chk("mul2_busy", 32'(rs_busy_status), 32'b11110);
        chk_issue("mul2", 1'b1, 1'b1, 32'hA4);
        chk("mul3_free_idx", 32'(rs_id_packet.free_idx), 32'd4);
        chk("mul3_free", 32'(rs_id_packet.free), 32'd0);
        tick();
        drive('0, 1'b0);
        #1;
        chk("mul3_busy", 32'(rs_busy_status), 32'b11110);
        chk_issue("mul3", 1'b0, 1'b0, 32'h0);

        // Removal: slot 1, out-of-range index, slot 3
        ex_rs_packet.remove_en  = 1'b1;
        ex_rs_packet.remove_idx = 3'd1;
        tick();
        chk("rm1_busy", 32'(rs_busy_status), 32'b11100);
        ex_rs_packet.remove_idx = 3'd7;
        tick();
        chk("rm7_busy", 32'(rs_busy_status), 32'b11100);
        ex_rs_packet.remove_idx = 3'd3;
        tick();
        chk("rm3_busy", 32'(rs_busy_status), 32'b10100);
        ex_rs_packet = '0;

        // ALU op into slot 0 held back by CDB reservation
        cdb_en = 1'b1;
        drive(mk(1'b0, 1'b0, ALU_ADD, 32'hA5), 1'b1);
        #1;
        chk("add_free_idx", 32'(rs_id_packet.free_idx), 32'd0);
        chk("add_free", 32'(rs_id_packet.free), 32'd1);
        tick();
        drive(mk(1'b0, 1'b0, ALU_MULHSU, 32'hA6), 1'b1);
        #1;
        chk("add_busy", 32'(rs_busy_status), 32'b10101);
        chk_issue("add_cdb", 1'b0, 1'b0, 32'h0);
        chk("mul4_free_idx", 32'(rs_id_packet.free_idx), 32'd3);
        tick();
        drive('0, 1'b0);
        #1;
        chk("mul4_busy", 32'(rs_busy_status), 32'b11101);
        chk_issue("cdb_on", 1'b1, 1'b1, 32'hA6);
        cdb_en = 1'b0;
        #1;
        chk_issue("cdb_off", 1'b1, 1'b0, 32'hA5);
        tick();
        chk_issue("after_alu", 1'b1, 1'b1, 32'hA6);
        tick();
        chk_issue("all_issued", 1'b0, 1'b0, 32'h0);

        // Fill all slots, then interrupt with concurrent dispatch
        drive(mk(1'b1, 1'b0, ALU_ADD, 32'hA7), 1'b1);
        tick();
        chk("full_busy", 32'(rs_busy_status), 32'b11111);
        interrupt = 1'b1;
        drive(mk(1'b0, 1'b1, ALU_ADD, 32'hBAD), 1'b1);
        #1;
        chk_issue("pre_int", 1'b1, 1'b0, 32'hA7);
        tick();
        chk("int_busy", 32'(rs_busy_status), 32'b00000);
        chk_issue("int", 1'b0, 1'b0, 32'h0);
        drive(mk(1'b0, 1'b0, ALU_XOR, 32'hBAD), 1'b1);
        tick();
        chk("int_disp_busy", 32'(rs_busy_status), 32'b00000);
        interrupt = 1'b0;

        // Asynchronous reset mid-operation
        drive(mk(1'b1, 1'b0, ALU_ADD, 32'hA8), 1'b1);
        tick();
        drive(mk(1'b0, 1'b0, ALU_MUL, 32'hA9), 1'b1);
        tick();
        drive(mk(1'b0, 1'b0, ALU_MUL, 32'hAA), 1'b0);
        #1;
        chk("pre_rst_busy", 32'(rs_busy_status), 32'b01010);
        chk("pre_rst_free_idx", 32'(rs_id_packet.free_idx), 32'd4);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(rs_busy_status), 32'b00000);
        chk("arst_free_idx", 32'(rs_id_packet.free_idx), 32'd3);
        chk("arst_free", 32'(rs_id_packet.free), 32'd1);
        chk_issue("arst", 1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b0;
        drive('0, 1'b0);
        tick();
        chk("post_rst_busy", 32'(rs_busy_status), 32'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
